// File: rtl/ps2_kbd_event_fifo_if.sv
// Handshake bundle between the PS/2 receiver/CPU side (master) and the keyboard event FIFO (slave).
interface ps2_kbd_event_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    code_i;
  logic          strobe_i;
  logic          err_i;
  logic          pop_i;
  logic          clear_i;
  logic [9:0]    data_o;
  logic          valid_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;
  logic [7:0]    err_count_o;

  modport master (
    output code_i, strobe_i, err_i, pop_i, clear_i,
    input  data_o, valid_o, count_o, overflow_o, err_count_o
  );

  modport slave (
    input  code_i, strobe_i, err_i, pop_i, clear_i,
    output data_o, valid_o, count_o, overflow_o, err_count_o
  );
endinterface

// File: rtl/ps2_kbd_event_fifo.sv
// Folds PS/2 set-2 prefix bytes (E0/F0/E1) into {break,extended,code} events and
// buffers them in a show-ahead FIFO drained by the CPU.
module ps2_kbd_event_fifo #(
  parameter int DEPTH      = 16,
  parameter int PAUSE_SKIP = 7
) (
  input  logic                    clk,
  input  logic                    reset_i,
  ps2_kbd_event_fifo_if.slave     bus
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SKW = (PAUSE_SKIP < 1) ? 1 : $clog2(PAUSE_SKIP + 1);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [SKW-1:0] SKIP_LD  = SKW'(PAUSE_SKIP);

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_E1 = 8'hE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e         state_q, state_d;
  logic [SKW-1:0] skip_q, skip_d;
  logic           push;
  logic [9:0]     push_data;

  logic [9:0]     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  rd_nxt;
  logic [AW:0]    count_q, count_d;
  logic [9:0]     data_q, data_d;
  logic           overflow_q, overflow_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  logic empty, full, do_pop, do_push, ovf_set;

  // Decoder: next state and the event (if any) produced by this byte
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    push      = 1'b0;
    push_data = 10'd0;
    if (bus.err_i) begin
      state_d = S_IDLE;
      skip_d  = '0;
    end else if (bus.strobe_i) begin
      case (state_q)
        S_IDLE: begin
          if (bus.code_i == B_E0) begin
            state_d = S_EXT;
          end else if (bus.code_i == B_F0) begin
            state_d = S_BRK;
          end else if (bus.code_i == B_E1) begin
            push      = 1'b1;
            push_data = {2'b00, bus.code_i};
            if (PAUSE_SKIP > 0) begin
              skip_d  = SKIP_LD;
              state_d = S_SKIP;
            end
          end else begin
            push      = 1'b1;
            push_data = {2'b00, bus.code_i};
          end
        end
        S_EXT: begin
          if (bus.code_i == B_F0) begin
            state_d = S_EXT_BRK;
          end else if (bus.code_i != B_E0) begin
            push      = 1'b1;
            push_data = {2'b01, bus.code_i};
            state_d   = S_IDLE;
          end
        end
        S_BRK: begin
          if (bus.code_i == B_E0) begin
            state_d = S_EXT_BRK;
          end else if (bus.code_i != B_F0) begin
            push      = 1'b1;
            push_data = {2'b10, bus.code_i};
            state_d   = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (bus.code_i != B_E0 && bus.code_i != B_F0) begin
            push      = 1'b1;
            push_data = {2'b11, bus.code_i};
            state_d   = S_IDLE;
          end
        end
        S_SKIP: begin
          if (skip_q <= SKW'(1)) begin
            skip_d  = '0;
            state_d = S_IDLE;
          end else begin
            skip_d = skip_q - SKW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          skip_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // FIFO control: a pop on a full FIFO frees the slot the same-edge push needs
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = bus.pop_i && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf_set = push && full && !do_pop;
  assign rd_nxt  = rd_ptr_q + AW'(1);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_nxt            : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW + 1)'(1);
    end

    // Head register keeps data_o registered and zero after reset
    data_d = data_q;
    if (do_push && (empty || (do_pop && count_q == (AW + 1)'(1)))) begin
      data_d = push_data;
    end else if (do_pop && count_q > (AW + 1)'(1)) begin
      data_d = mem_q[rd_nxt];
    end

    overflow_d = overflow_q;
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (bus.clear_i) begin
      overflow_d = 1'b0;
    end

    err_cnt_d = err_cnt_q;
    if (bus.err_i) begin
      err_cnt_d = bus.clear_i ? 8'd1 : sat_inc8(err_cnt_q);
    end else if (bus.clear_i) begin
      err_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.data_o      = data_q;
  assign bus.valid_o     = !empty;
  assign bus.count_o     = count_q;
  assign bus.overflow_o  = overflow_q;
  assign bus.err_count_o = err_cnt_q;

endmodule

// File: tb/tb_ps2_kbd_event_fifo.sv
// Directed bench for ps2_kbd_event_fifo: prefix folding, errors, overflow and reset.
module tb_ps2_kbd_event_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ps2_kbd_event_fifo_if #(.DEPTH(16)) bus ();

  ps2_kbd_event_fifo #(.DEPTH(16), .PAUSE_SKIP(7)) dut (
    .clk     (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    bus.code_i   = c;
    bus.strobe_i = 1'b1;
    @(negedge clk);
    bus.strobe_i = 1'b0;
  endtask

  task automatic pop1();
    @(negedge clk);
    bus.pop_i = 1'b1;
    @(negedge clk);
    bus.pop_i = 1'b0;
  endtask

  task automatic clear1();
    @(negedge clk);
    bus.clear_i = 1'b1;
    @(negedge clk);
    bus.clear_i = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus.count_o !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.count_o); end
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.valid_o); end
    total++; if (bus.data_o !== 10'h000) begin bad++; $display("FAIL rst_data got=%h exp=000", bus.data_o); end
    total++; if (bus.overflow_o !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", bus.overflow_o); end
    total++; if (bus.err_count_o !== 8'd0) begin bad++; $display("FAIL rst_errc got=%0d exp=0", bus.err_count_o); end
  endtask

  task automatic test_make();
    @(negedge clk);
    bus.code_i   = 8'h1C;
    bus.strobe_i = 1'b1;
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL make_early got=%b exp=0", bus.valid_o); end
    @(negedge clk);
    bus.strobe_i = 1'b0;
    total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL make_valid got=%b exp=1", bus.valid_o); end
    total++; if (bus.data_o !== 10'h01C) begin bad++; $display("FAIL make_data got=%h exp=01c", bus.data_o); end
    total++; if (bus.count_o !== 5'd1) begin bad++; $display("FAIL make_count got=%0d exp=1", bus.count_o); end
    pop1();
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL make_pop_valid got=%b exp=0", bus.valid_o); end
    total++; if (bus.count_o !== 5'd0) begin bad++; $display("FAIL make_pop_count got=%0d exp=0", bus.count_o); end
  endtask

  task automatic test_ext_break();
    send(8'hE0); send(8'hF0); send(8'h74);
    total++; if (bus.count_o !== 5'd1) begin bad++; $display("FAIL extbrk_count got=%0d exp=1", bus.count_o); end
    total++; if (bus.data_o !== 10'h374) begin bad++; $display("FAIL extbrk_data got=%h exp=374", bus.data_o); end
    send(8'hF0); send(8'h1C);
    total++; if (bus.count_o !== 5'd2) begin bad++; $display("FAIL brk_count got=%0d exp=2", bus.count_o); end
    pop1();
    total++; if (bus.data_o !== 10'h21C) begin bad++; $display("FAIL brk_data got=%h exp=21c", bus.data_o); end
    pop1();
    total++; if (bus.count_o !== 5'd0) begin bad++; $display("FAIL brk_drain got=%0d exp=0", bus.count_o); end
  endtask

  task automatic test_pause();
    logic [7:0] seq [9];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
    for (int i = 0; i < 9; i++) send(seq[i]);
    total++; if (bus.count_o !== 5'd2) begin bad++; $display("FAIL pause_count got=%0d exp=2", bus.count_o); end
    total++; if (bus.data_o !== 10'h0E1) begin bad++; $display("FAIL pause_head got=%h exp=0e1", bus.data_o); end
    pop1();
    total++; if (bus.data_o !== 10'h01C) begin bad++; $display("FAIL pause_next got=%h exp=01c", bus.data_o); end
    pop1();
  endtask

  task automatic test_error();
    send(8'hE0);
    @(negedge clk); bus.err_i = 1'b1;
    @(negedge clk); bus.err_i = 1'b0;
    send(8'h74);
    total++; if (bus.data_o !== 10'h074) begin bad++; $display("FAIL err_data got=%h exp=074", bus.data_o); end
    total++; if (bus.err_count_o !== 8'd1) begin bad++; $display("FAIL err_cnt got=%0d exp=1", bus.err_count_o); end
    // byte arriving together with an error is discarded
    @(negedge clk); bus.code_i = 8'h5A; bus.strobe_i = 1'b1; bus.err_i = 1'b1;
    @(negedge clk); bus.strobe_i = 1'b0; bus.err_i = 1'b0;
    total++; if (bus.count_o !== 5'd1) begin bad++; $display("FAIL err_discard got=%0d exp=1", bus.count_o); end
    total++; if (bus.err_count_o !== 8'd2) begin bad++; $display("FAIL err_cnt2 got=%0d exp=2", bus.err_count_o); end
    pop1();
    clear1();
    total++; if (bus.err_count_o !== 8'd0) begin bad++; $display("FAIL err_clear got=%0d exp=0", bus.err_count_o); end
    @(negedge clk); bus.clear_i = 1'b1; bus.err_i = 1'b1;
    @(negedge clk); bus.clear_i = 1'b0; bus.err_i = 1'b0;
    total++; if (bus.err_count_o !== 8'd1) begin bad++; $display("FAIL err_clr_win got=%0d exp=1", bus.err_count_o); end
    clear1();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 16; i++) send(8'(i));
    total++; if (bus.overflow_o !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", bus.overflow_o); end
    send(8'h11);
    total++; if (bus.count_o !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", bus.count_o); end
    total++; if (bus.overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow_o); end
    for (int i = 1; i <= 16; i++) begin
      total++; if (bus.data_o !== 10'(i)) begin bad++; $display("FAIL ovf_entry%0d got=%h exp=%h", i, bus.data_o, 10'(i)); end
      pop1();
    end
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL ovf_drain got=%b exp=0", bus.valid_o); end
    clear1();
    total++; if (bus.overflow_o !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", bus.overflow_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) send(8'h30 + 8'(i));
    @(negedge clk); bus.code_i = 8'h2A; bus.strobe_i = 1'b1; bus.pop_i = 1'b1;
    @(negedge clk); bus.strobe_i = 1'b0; bus.pop_i = 1'b0;
    total++; if (bus.count_o !== 5'd16) begin bad++; $display("FAIL fpp_count got=%0d exp=16", bus.count_o); end
    total++; if (bus.overflow_o !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%b exp=0", bus.overflow_o); end
    total++; if (bus.data_o !== 10'h031) begin bad++; $display("FAIL fpp_head got=%h exp=031", bus.data_o); end
    for (int i = 0; i < 15; i++) pop1();
    total++; if (bus.data_o !== 10'h02A) begin bad++; $display("FAIL fpp_tail got=%h exp=02a", bus.data_o); end
    total++; if (bus.count_o !== 5'd1) begin bad++; $display("FAIL fpp_tail_cnt got=%0d exp=1", bus.count_o); end
    pop1();
    pop1();
    total++; if (bus.count_o !== 5'd0) begin bad++; $display("FAIL empty_pop got=%0d exp=0", bus.count_o); end
    @(negedge clk); bus.code_i = 8'h55; bus.strobe_i = 1'b1; bus.pop_i = 1'b1;
    @(negedge clk); bus.strobe_i = 1'b0; bus.pop_i = 1'b0;
    total++; if (bus.count_o !== 5'd1) begin bad++; $display("FAIL epp_count got=%0d exp=1", bus.count_o); end
    total++; if (bus.data_o !== 10'h055) begin bad++; $display("FAIL epp_data got=%h exp=055", bus.data_o); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); bus.err_i = 1'b1;
    @(negedge clk); bus.err_i = 1'b0;
    send(8'hE0);
    #2 rst = 1'b1;
    #1;
    total++; if (bus.count_o !== 5'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", bus.count_o); end
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", bus.valid_o); end
    total++; if (bus.data_o !== 10'h000) begin bad++; $display("FAIL arst_data got=%h exp=000", bus.data_o); end
    total++; if (bus.err_count_o !== 8'd0) begin bad++; $display("FAIL arst_errc got=%0d exp=0", bus.err_count_o); end
    @(negedge clk); rst = 1'b0;
    send(8'h1C);
    total++; if (bus.data_o !== 10'h01C) begin bad++; $display("FAIL arst_next got=%h exp=01c", bus.data_o); end
    total++; if (bus.count_o !== 5'd1) begin bad++; $display("FAIL arst_next_cnt got=%0d exp=1", bus.count_o); end
  endtask

  initial begin
    bus.code_i   = 8'h00;
    bus.strobe_i = 1'b0;
    bus.err_i    = 1'b0;
    bus.pop_i    = 1'b0;
    bus.clear_i  = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_make();
    test_ext_break();
    test_pause();
    test_error();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_event_fifo.md
Name: ps2_kbd_event_fifo

Overview:
- Sits between the PS/2 keyboard receiver (ps2kbd) and the SoC keyboard register interface.
- Consumes raw PS/2 set-2 scancode bytes from the receiver: code, strobe and error flag.
- Folds the E0 (extended), F0 (break) and E1 (pause) prefix sequences into single key events.
- Buffers decoded events in a show-ahead FIFO that the CPU drains through a pop strobe.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
- PAUSE_SKIP, 7, number of bytes discarded after an E1 prefix.

Ports:
- clk  input  1  system clock (25 MHz in the current SoC).
- reset_i  input  1  asynchronous, active-high reset.
- code_i  input  8  scancode byte from the PS/2 receiver.
- strobe_i  input  1  one-cycle pulse; code_i is valid in this cycle.
- err_i  input  1  one-cycle pulse; receiver frame or parity error.
- pop_i  input  1  removes the head entry when valid_o=1.
- data_o  output  10  head event: [9]=break, [8]=extended, [7:0]=code.
- valid_o  output  1  FIFO not empty.
- count_o  output  $clog2(DEPTH)+1  number of entries stored.
- overflow_o  output  1  sticky flag: an event was dropped because the FIFO was full.
- clear_i  input  1  synchronous clear of overflow_o and err_count_o.
- err_count_o  output  8  saturating count of err_i pulses.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - decoder returns to IDLE and the skip counter is cleared;
  - FIFO is emptied: count_o=0, valid_o=0, data_o=0;
  - overflow_o=0 and err_count_o=0.
- Decoder FSM, advanced only on edges where strobe_i=1 and err_i=0:
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> push {0,0,E1}, load skip=PAUSE_SKIP, go to SKIP; any other byte -> push {0,0,code}, stay in IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay in EXT; any other byte -> push {0,1,code}, go to IDLE.
  - BRK: any byte other than E0/F0 -> push {1,0,code}, go to IDLE; E0 -> EXT_BRK; F0 -> stay in BRK.
  - EXT_BRK: any byte other than E0/F0 -> push {1,1,code}, go to IDLE; E0/F0 -> stay in EXT_BRK.
  - SKIP: each byte decrements skip with no push; after the byte that takes skip to 0, go to IDLE.
- Error handling: if err_i=1 on an edge, regardless of strobe_i:
  - any byte in that cycle is discarded;
  - FSM goes to IDLE and skip is cleared;
  - err_count_o increments and saturates at 255.
- Latency: a push occurs on the same edge that samples the terminating strobe_i. valid_o, data_o and count_o reflect the push after that edge, i.e. 1 cycle after strobe_i.
- FIFO data path:
  - show-ahead: data_o always shows the head entry while valid_o=1;
  - when empty, data_o holds its last value and is don't-care;
  - read and write pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
- Pop: pop_i with valid_o=0 is ignored. pop_i with valid_o=1 advances the head on that edge.
- Full, push without pop: the new event is dropped, overflow_o is set, and FIFO contents are unchanged.
- Full, push and pop on the same edge: both take effect, count stays at DEPTH, and overflow_o is not set.
- Empty, push and pop on the same edge: the pop is ignored and the push is accepted (count becomes 1).
- clear_i: clears overflow_o and err_count_o on that edge. If an overflow or an error happens on the same edge, the set/increment wins: overflow_o=1, err_count_o=1.
- count_o is always the exact entry count, 0..DEPTH.

Test Plan:
- Make key: strobe 1C -> one entry, data_o=0x01C, valid_o=1 one cycle after the strobe; pop -> valid_o=0, count_o=0.
- Extended break: strobes E0, F0, 74 -> exactly one entry, data_o=0x374. Then F0, 1C -> data_o after pop = 0x21C.
- Pause sequence: E1 14 77 E1 F0 14 F0 77, then 1C -> two entries, 0x0E1 then 0x01C; FSM back in IDLE.
- Error mid-prefix: E0, then an err_i pulse, then 74 -> entry 0x074 (not extended); err_count_o=1. Then clear_i -> err_count_o=0.
- Overflow: DEPTH+1 make codes 01..11 without pop -> count_o=16, overflow_o=1, entries are 01..10 in order, and 11 is lost.
- Full with simultaneous push/pop: with 16 entries, strobe 2A together with pop_i -> count_o=16, overflow_o=0, new tail entry is 0x02A. An asynchronous reset asserted mid-E0 -> all outputs zero, and the next 1C gives 0x01C.
